// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer
// Queues convolution jobs from a host and runs them one at a time on the
// convolution core. Each run is supervised with a Z-write counter and a
// watchdog. A result record (write count + error code) is returned per job
// through a valid/ready handshake.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   job_valid/job_ready          host job handshake (job_ready = !full && !abort)
//   job_sizeX/job_sizeY/job_shape  job configuration (shape 0 = full, 1 = same)
//   abort                        flush queue, terminate the running job
//   conv_start                   start level to the core, held until busy seen
//   conv_sizeX/conv_sizeY/conv_shape  registered job configuration to the core
//   conv_busy/conv_done/conv_writeZ   core status, done pulse, Z write strobe
//   res_valid/res_ready          result handshake
//   res_len                      Z writes counted for the job (saturating)
//   res_err                      00 ok, 01 length mismatch, 10 timeout, 11 rejected/aborted
//   busy                         sequencer not idle or queue non-empty
module conv_job_sequencer #(
  parameter int SIZE_W         = 5,
  parameter int ZADDR_W        = 6,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [SIZE_W-1:0]  job_sizeX,
  input  logic [SIZE_W-1:0]  job_sizeY,
  input  logic               job_shape,
  input  logic               abort,
  output logic               conv_start,
  output logic [SIZE_W-1:0]  conv_sizeX,
  output logic [SIZE_W-1:0]  conv_sizeY,
  output logic               conv_shape,
  input  logic               conv_busy,
  input  logic               conv_done,
  input  logic               conv_writeZ,
  output logic               res_valid,
  output logic [ZADDR_W-1:0] res_len,
  output logic [1:0]         res_err,
  input  logic               res_ready,
  output logic               busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W:0]  DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t state;

  // ---------------- job queue ----------------
  logic [SIZE_W-1:0] fifo_x     [FIFO_DEPTH];
  logic [SIZE_W-1:0] fifo_y     [FIFO_DEPTH];
  logic              fifo_shape [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [SIZE_W-1:0] head_x;
  logic [SIZE_W-1:0] head_y;
  logic              head_shape;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign job_ready  = !full && !abort;
  assign push       = job_valid && job_ready;
  // abort in IDLE flushes the queue, so nothing may be popped that cycle
  assign pop        = (state == S_IDLE) && !empty && !abort;
  assign head_x     = fifo_x[rd_ptr];
  assign head_y     = fifo_y[rd_ptr];
  assign head_shape = fifo_shape[rd_ptr];
  assign busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr]     <= job_sizeX;
      fifo_y[wr_ptr]     <= job_sizeY;
      fifo_shape[wr_ptr] <= job_shape;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- run supervision ----------------
  logic [ZADDR_W-1:0] zcnt;
  logic [ZADDR_W-1:0] zcnt_next;
  logic [WD_W-1:0]    wdog;
  logic [ZADDR_W-1:0] exp_len;
  logic               running;
  logic               wd_expire;
  logic               finish;
  logic [1:0]         finish_err;

  assign running   = (state == S_START) || (state == S_WAIT);
  // the write seen in the terminating cycle still belongs to the job
  assign zcnt_next = (running && conv_writeZ && (zcnt != '1)) ? zcnt + 1'b1 : zcnt;
  assign wd_expire = running && (wdog == WD_LAST);
  assign exp_len   = conv_shape ? ZADDR_W'(conv_sizeX)
                                : ZADDR_W'(conv_sizeX) + ZADDR_W'(conv_sizeY) - ZADDR_W'(1);

  // termination cause, highest priority first: abort, timeout, done
  always_comb begin
    finish     = 1'b0;
    finish_err = 2'b00;
    if (abort) begin
      finish     = 1'b1;
      finish_err = 2'b11;
    end else if (wd_expire) begin
      finish     = 1'b1;
      finish_err = 2'b10;
    end else if (conv_done) begin
      finish     = 1'b1;
      finish_err = (zcnt_next == exp_len) ? 2'b00 : 2'b01;
    end
  end

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      conv_start <= 1'b0;
      conv_sizeX <= '0;
      conv_sizeY <= '0;
      conv_shape <= 1'b0;
      res_valid  <= 1'b0;
      res_len    <= '0;
      res_err    <= 2'b00;
      zcnt       <= '0;
      wdog       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            conv_sizeX <= head_x;
            conv_sizeY <= head_y;
            conv_shape <= head_shape;
            zcnt       <= '0;
            wdog       <= '0;
            if ((head_x == '0) || (head_y == '0)) begin
              state     <= S_REPORT;
              res_valid <= 1'b1;
              res_len   <= '0;
              res_err   <= 2'b11;
            end else begin
              state      <= S_START;
              conv_start <= 1'b1;
            end
          end
        end
        S_START, S_WAIT: begin
          zcnt <= zcnt_next;
          wdog <= wdog + 1'b1;
          if (finish) begin
            state      <= S_REPORT;
            conv_start <= 1'b0;
            res_valid  <= 1'b1;
            res_len    <= zcnt_next;
            res_err    <= finish_err;
          end else if ((state == S_START) && conv_busy) begin
            state      <= S_WAIT;
            conv_start <= 1'b0;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
module tb_conv_job_sequencer;
  localparam int SW = 5;
  localparam int ZW = 6;
  localparam int FD = 4;
  localparam int TO = 1023;
  localparam int ZMAX = (1 << ZW) - 1;

  logic          clk;
  logic          rstn;
  logic          job_valid;
  logic          job_ready;
  logic [SW-1:0] job_sizeX;
  logic [SW-1:0] job_sizeY;
  logic          job_shape;
  logic          abort;
  logic          conv_start;
  logic [SW-1:0] conv_sizeX;
  logic [SW-1:0] conv_sizeY;
  logic          conv_shape;
  logic          conv_busy;
  logic          conv_done;
  logic          conv_writeZ;
  logic          res_valid;
  logic [ZW-1:0] res_len;
  logic [1:0]    res_err;
  logic          res_ready;
  logic          busy;

  conv_job_sequencer #(
    .SIZE_W(SW),
    .ZADDR_W(ZW),
    .FIFO_DEPTH(FD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_sizeX(job_sizeX), .job_sizeY(job_sizeY), .job_shape(job_shape),
    .abort(abort),
    .conv_start(conv_start), .conv_sizeX(conv_sizeX), .conv_sizeY(conv_sizeY),
    .conv_shape(conv_shape),
    .conv_busy(conv_busy), .conv_done(conv_done), .conv_writeZ(conv_writeZ),
    .res_valid(res_valid), .res_len(res_len), .res_err(res_err), .res_ready(res_ready),
    .busy(busy)
  );

  typedef struct {
    int len;
    int err;
  } res_t;

  // how the core model behaves for one started job
  typedef struct {
    int writes;
    bit hang;
    bit no_busy;
    int abort_after;
  } plan_t;

  res_t  exp_q[$];
  plan_t plan_q[$];

  int total;
  int bad;
  int cyc;
  bit stall;
  int rr_mode;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    total++;
    bad++;
    $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic plan_t mk_plan(input int w, input bit h, input bit nb, input int ab);
    plan_t p;
    p.writes = w;
    p.hang = h;
    p.no_busy = nb;
    p.abort_after = ab;
    return p;
  endfunction

  // reference: what result record a job must produce given how the core behaves
  function automatic res_t model(input int x, input int y, input int sh, input plan_t p);
    res_t r;
    int e;
    if (x == 0 || y == 0) begin
      r.len = 0;
      r.err = 3;
    end else if (p.abort_after >= 0) begin
      r.len = p.abort_after;
      r.err = 3;
    end else begin
      r.len = (p.writes > ZMAX) ? ZMAX : p.writes;
      e = (sh != 0) ? x : x + y - 1;
      if (p.hang) r.err = 2;
      else        r.err = (r.len == e) ? 0 : 1;
    end
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       res_ready = ($urandom_range(0, 3) != 0);
        1:       res_ready = 1'b1;
        default: res_ready = 1'b0;
      endcase
    end
  end

  // core model: reacts to conv_start according to the next queued plan
  initial begin
    plan_t cp;
    bit active;
    bit chk_drop;
    bit ghost;
    int phase;
    int delay;
    int left;
    int written;
    int t0;
    conv_busy = 1'b0;
    conv_done = 1'b0;
    conv_writeZ = 1'b0;
    abort = 1'b0;
    active = 0;
    chk_drop = 0;
    ghost = 0;
    phase = 0;
    delay = 0;
    left = 0;
    written = 0;
    t0 = 0;
    cp = mk_plan(0, 0, 0, -1);
    forever begin
      @(posedge clk);
      #1;
      conv_done = 1'b0;
      conv_writeZ = 1'b0;
      abort = 1'b0;
      if (!rstn) begin
        active = 0;
        chk_drop = 0;
        conv_busy = 1'b0;
        continue;
      end
      if (chk_drop) begin
        check("start_drop", int'(conv_start), 0);
        chk_drop = 0;
      end
      if (!conv_start) ghost = 0;
      if (!active && conv_start && !stall) begin
        if (plan_q.size() == 0) begin
          if (!ghost) fail("start_without_plan", 1, 0);
          ghost = 1;
        end else begin
          cp = plan_q.pop_front();
          active = 1;
          phase = 0;
          t0 = cyc;
          delay = cp.no_busy ? 0 : $urandom_range(0, 3);
          left = cp.writes;
          written = 0;
        end
      end
      if (active) begin
        case (phase)
          0: begin
            if (cp.no_busy) begin
              phase = 1;
            end else if (delay == 0) begin
              conv_busy = 1'b1;
              chk_drop = 1;
              phase = 1;
            end else begin
              check("start_held", int'(conv_start), 1);
              delay--;
            end
          end
          1: begin
            if (cp.hang) begin
              if (res_valid) begin
                check("timeout_cycles", cyc - t0, TO);
                conv_busy = 1'b0;
                phase = 2;
              end else if (left > 0 && $urandom_range(0, 3) != 0) begin
                conv_writeZ = 1'b1;
                left--;
              end
            end else if (cp.abort_after >= 0) begin
              if (written == cp.abort_after) begin
                abort = 1'b1;
                #2;
                check("abort_ready", int'(job_ready), 0);
                phase = 3;
              end else if ($urandom_range(0, 3) != 0) begin
                conv_writeZ = 1'b1;
                written++;
              end
            end else begin
              if (left == 0) begin
                conv_done = 1'b1;
                conv_busy = 1'b0;
                active = 0;
              end else if (left == 1 && $urandom_range(0, 1) == 1) begin
                conv_writeZ = 1'b1;
                conv_done = 1'b1;
                conv_busy = 1'b0;
                active = 0;
              end else if ($urandom_range(0, 3) != 0) begin
                conv_writeZ = 1'b1;
                left--;
              end
            end
          end
          2: begin
            conv_done = 1'b1;  // late done after a timeout, must be ignored
            active = 0;
          end
          default: begin
            conv_busy = 1'b0;
            active = 0;
          end
        endcase
      end
    end
  end

  // monitor: scoreboard pops on every result handshake
  initial begin
    res_t e;
    bit prev_valid;
    int prev_len;
    int prev_err;
    prev_valid = 0;
    prev_len = 0;
    prev_err = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_valid = 0;
        continue;
      end
      if (res_valid) begin
        if (prev_valid) begin
          check("res_len_stable", int'(res_len), prev_len);
          check("res_err_stable", int'(res_err), prev_err);
        end
        prev_len = int'(res_len);
        prev_err = int'(res_err);
        prev_valid = 1;
        if (res_ready) begin
          prev_valid = 0;
          if (exp_q.size() == 0) begin
            fail("unexpected_result", int'(res_len), -1);
          end else begin
            e = exp_q.pop_front();
            check("res_len", int'(res_len), e.len);
            check("res_err", int'(res_err), e.err);
          end
        end
      end else begin
        prev_valid = 0;
      end
    end
  end

  task automatic push(input int x, input int y, input int sh,
                      input bit exp_on, input bit plan_on, input plan_t p);
    bit acc;
    bit ok;
    ok = 0;
    acc = 0;
    job_valid = 1'b1;
    job_sizeX = SW'(x);
    job_sizeY = SW'(y);
    job_shape = sh[0];
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      acc = job_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    job_valid = 1'b0;
    if (!ok) begin
      fail("push_accept", 0, 1);
    end else begin
      if (exp_on) exp_q.push_back(model(x, y, sh, p));
      if (plan_on) plan_q.push_back(p);
    end
  endtask

  task automatic drain(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && plan_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) fail("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_conv_start"}, int'(conv_start), 0);
    check({tag, "_conv_sizeX"}, int'(conv_sizeX), 0);
    check({tag, "_conv_sizeY"}, int'(conv_sizeY), 0);
    check({tag, "_conv_shape"}, int'(conv_shape), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_len"}, int'(res_len), 0);
    check({tag, "_res_err"}, int'(res_err), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_job_ready"}, int'(job_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    plan_t p;
    int x;
    int y;
    int sh;
    int e;
    int w;
    int r;
    total = 0;
    bad = 0;
    stall = 0;
    rr_mode = 1;
    rstn = 1'b0;
    job_valid = 1'b0;
    job_sizeX = '0;
    job_sizeY = '0;
    job_shape = 1'b0;
    #12;
    check_reset_outputs("reset");
    #6 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // full-shape job with the correct write count, start latency and config
    p = mk_plan(14, 0, 0, -1);
    push(10, 5, 0, 1, 1, p);
    @(posedge clk);
    #1;
    check("start_latency", int'(conv_start), 1);
    check("cfg_sizeX", int'(conv_sizeX), 10);
    check("cfg_sizeY", int'(conv_sizeY), 5);
    check("cfg_shape", int'(conv_shape), 0);
    drain(300);

    // same-shape job with a short write count
    p = mk_plan(9, 0, 0, -1);
    push(10, 5, 1, 1, 1, p);
    drain(300);

    // queue fills while the core is stalled
    stall = 1;
    for (int j = 0; j < 5; j++) begin
      x = $urandom_range(1, 31);
      y = $urandom_range(1, 31);
      sh = $urandom_range(0, 1);
      e = (sh != 0) ? x : x + y - 1;
      push(x, y, sh, 1, 1, mk_plan(e, 0, 0, -1));
    end
    @(negedge clk);
    check("ready_when_full", int'(job_ready), 0);
    check("busy_when_full", int'(busy), 1);
    @(posedge clk);
    #1;
    stall = 0;
    drain(2000);

    // zero-size job is rejected without starting the core
    push(0, 7, 0, 1, 0, mk_plan(0, 0, 0, -1));
    @(posedge clk);
    #1;
    check("reject_res_valid", int'(res_valid), 1);
    check("reject_no_start", int'(conv_start), 0);
    drain(100);

    // core never finishes: watchdog, then a late done is ignored
    push(10, 5, 0, 1, 1, mk_plan(3, 1, 0, -1));
    drain(2000);
    repeat (10) @(posedge clk);
    #1;

    // randomized traffic with random host back-pressure
    rr_mode = 0;
    for (int j = 0; j < 40; j++) begin
      x = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
      y = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
      sh = $urandom_range(0, 1);
      e = (sh != 0) ? x : x + y - 1;
      r = $urandom_range(0, 99);
      if (r < 60)      w = e;
      else if (r < 90) w = e + $urandom_range(0, 6) - 3;
      else             w = 60 + $urandom_range(0, 8);
      if (w < 0) w = 0;
      p = mk_plan(w, 0, ($urandom_range(0, 9) == 0), -1);
      push(x, y, sh, 1, (x != 0 && y != 0), p);
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        @(posedge clk);
        #1;
      end
    end
    drain(8000);

    // abort mid-run with two jobs still queued
    rr_mode = 1;
    stall = 1;
    push(12, 9, 0, 1, 1, mk_plan(6, 0, 0, 6));
    push(4, 4, 1, 0, 0, mk_plan(4, 0, 0, -1));
    push(5, 6, 0, 0, 0, mk_plan(10, 0, 0, -1));
    stall = 0;
    drain(500);
    check("abort_busy", int'(busy), 0);
    check("abort_job_ready", int'(job_ready), 1);

    // asynchronous reset in the middle of a run
    push(20, 20, 0, 1, 1, mk_plan(39, 0, 0, -1));
    repeat (8) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check_reset_outputs("midrun");
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    push(3, 4, 1, 1, 1, mk_plan(3, 0, 0, -1));
    drain(300);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
